// File: rtl/cpu64_l2_pkg.sv
// rtl/cpu64_l2_pkg.sv - L2 geometry constants and writeback engine state encoding
package cpu64_l2_pkg;

   localparam int TAG_W      = 50;
   localparam int IDX_W      = 8;
   localparam int WAY_W      = 4;
   localparam int BEATS      = 8;
   localparam int LINE_BYTES = 64;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int BEAT_W     = $clog2(BEATS);

   typedef enum logic [2:0] {
      WB_IDLE  = 3'd0,
      WB_CHECK = 3'd1,
      WB_ADDR  = 3'd2,
      WB_DATA  = 3'd3,
      WB_RESP  = 3'd4,
      WB_CLEAN = 3'd5,
      WB_DONE  = 3'd6
   } wb_state_e;

   // Line-aligned memory byte address of a cached line.
   function automatic logic [63:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cpu64_l2_wb_engine.sv
// rtl/cpu64_l2_wb_engine.sv - reads one dirty L2 victim line, streams it to memory, clears its dirty bit
module cpu64_l2_wb_engine
   import cpu64_l2_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,

   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [IDX_W-1:0]   req_index_i,
   input  logic [WAY_W-1:0]   req_way_i,

   output logic [IDX_W-1:0]   arr_index_o,
   output logic [2:0]         arr_word_o,
   output logic [WAY_W-1:0]   arr_way_o,
   input  logic [63:0]        arr_rdata_i,
   input  logic [TAG_W-1:0]   arr_tag_i,
   input  logic               arr_valid_i,
   input  logic               arr_dirty_i,
   output logic               arr_we_o,
   output logic [7:0]         arr_be_o,
   output logic [TAG_W-1:0]   arr_tag_o,
   output logic               arr_set_valid_o,
   output logic               arr_set_dirty_o,

   output logic               mem_aw_valid_o,
   input  logic               mem_aw_ready_i,
   output logic [63:0]        mem_addr_o,
   output logic               mem_w_valid_o,
   input  logic               mem_w_ready_i,
   output logic [63:0]        mem_wdata_o,
   output logic               mem_wlast_o,
   input  logic               mem_b_valid_i,
   output logic               mem_b_ready_o,
   input  logic               mem_b_err_i,

   output logic               busy_o,
   output logic               done_o,
   output logic               skipped_o,
   output logic               err_o
);

   wb_state_e             state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [WAY_W-1:0]      way_q;
   logic [TAG_W-1:0]      tag_q;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  skip_q, skip_d;
   logic                  err_q, err_d;
   logic                  accept;
   logic                  last_beat;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= WB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q  <= '0;
         way_q  <= '0;
         tag_q  <= '0;
         beat_q <= '0;
         skip_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            idx_q <= req_index_i;
            way_q <= req_way_i;
         end
         if (state_q == WB_CHECK) begin
            tag_q <= arr_tag_i;
         end
         beat_q <= beat_d;
         skip_q <= skip_d;
         err_q  <= err_d;
      end
   end

   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      skip_d         = skip_q;
      err_d          = err_q;
      accept         = 1'b0;
      req_ready_o    = 1'b0;
      arr_word_o     = 3'd0;
      arr_we_o       = 1'b0;
      mem_aw_valid_o = 1'b0;
      mem_w_valid_o  = 1'b0;
      mem_wlast_o    = 1'b0;
      mem_b_ready_o  = 1'b0;
      done_o         = 1'b0;

      case (state_q)
         WB_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept  = 1'b1;
               skip_d  = 1'b0;
               err_d   = 1'b0;
               beat_d  = '0;
               state_d = WB_CHECK;
            end
         end
         WB_CHECK: begin
            arr_word_o = 3'd0;
            if (!(arr_valid_i && arr_dirty_i)) begin
               skip_d  = 1'b1;
               state_d = WB_DONE;
            end else begin
               state_d = WB_ADDR;
            end
         end
         WB_ADDR: begin
            mem_aw_valid_o = 1'b1;
            if (mem_aw_ready_i) begin
               beat_d  = '0;
               state_d = WB_DATA;
            end
         end
         WB_DATA: begin
            // Beat only advances on a handshake, so the array word (and thus wdata) holds under stall.
            arr_word_o    = beat_q;
            mem_w_valid_o = 1'b1;
            mem_wlast_o   = last_beat;
            if (mem_w_ready_i) begin
               beat_d = beat_q + BEAT_W'(1);
               if (last_beat) begin
                  state_d = WB_RESP;
               end
            end
         end
         WB_RESP: begin
            mem_b_ready_o = 1'b1;
            if (mem_b_valid_i) begin
               if (mem_b_err_i) begin
                  err_d   = 1'b1;
                  state_d = WB_DONE;
               end else begin
                  state_d = WB_CLEAN;
               end
            end
         end
         WB_CLEAN: begin
            arr_we_o = 1'b1;
            state_d  = WB_DONE;
         end
         WB_DONE: begin
            done_o  = 1'b1;
            state_d = WB_IDLE;
         end
         default: begin
            state_d = WB_IDLE;
         end
      endcase
   end

   // Dirty clear rewrites tag/valid in place; zero byte enables leave the data untouched.
   assign arr_index_o     = idx_q;
   assign arr_way_o       = way_q;
   assign arr_be_o        = 8'h00;
   assign arr_tag_o       = tag_q;
   assign arr_set_valid_o = 1'b1;
   assign arr_set_dirty_o = 1'b0;

   assign mem_addr_o  = line_addr(tag_q, idx_q);
   assign mem_wdata_o = arr_rdata_i;

   assign busy_o    = (state_q != WB_IDLE);
   assign skipped_o = done_o & skip_q;
   assign err_o     = done_o & err_q;

endmodule

// File: doc/cpu64_l2_wb_engine.md
# cpu64_l2_wb_engine

Dirty-line writeback engine for the 256 KiB, 16-way, 64 B-line L2. It sits between the L2 controller and the L2 data/tag/valid/dirty arrays on one side and the memory write channel on the other. On request it reads one victim line (index, way) out of the arrays as 8 × 64-bit beats and streams it to memory. After a good response it clears the line's dirty bit in place.

## Interface
- TAG_W, 50, tag bits per line
- IDX_W, 8, set index bits (256 sets)
- WAY_W, 4, way select bits (16 ways)
- BEATS, 8, 64-bit words per line
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  writeback request
- req_ready_o  out  1  engine idle, request accepted when valid&ready
- req_index_i  in  IDX_W  victim set
- req_way_i  in  WAY_W  victim way
- arr_index_o  out  IDX_W  array read/write index
- arr_word_o  out  3  array word select
- arr_way_o  out  WAY_W  array way select
- arr_rdata_i  in  64  selected word (combinational array read)
- arr_tag_i  in  TAG_W  selected tag
- arr_valid_i  in  1  selected valid bit
- arr_dirty_i  in  1  selected dirty bit
- arr_we_o  out  1  array write strobe (dirty-clear only)
- arr_be_o  out  8  byte enables, constant 8'h00
- arr_tag_o  out  TAG_W  tag written back (latched tag)
- arr_set_valid_o / arr_set_dirty_o  out  1 each  constant 1 / 0
- mem_aw_valid_o / mem_aw_ready_i  out/in  1  address handshake
- mem_addr_o  out  64  {tag, index, 6'b0}
- mem_w_valid_o / mem_w_ready_i  out/in  1  data handshake
- mem_wdata_o  out  64  beat data
- mem_wlast_o  out  1  beat 7
- mem_b_valid_i / mem_b_ready_o  in/out  1  response handshake
- mem_b_err_i  in  1  response error
- busy_o  out  1  engine not in IDLE
- done_o  out  1  one-cycle completion pulse
- skipped_o, err_o  out  1  completion qualifiers, valid with done_o

## Operation
- States: IDLE, CHECK, ADDR, DATA, RESP, CLEAN, DONE.
- IDLE: req_ready_o=1. On accept, latch index/way and go to CHECK.
- In every state except IDLE, arr_index_o and arr_way_o are driven from the latched values.
- CHECK: arr_word_o=0. Sample arr_valid_i, arr_dirty_i and arr_tag_i, and latch the tag.
- CHECK exit: if !(valid&dirty), go to DONE with skipped_o=1. Otherwise go to ADDR.
- ADDR: mem_aw_valid_o=1 and mem_addr_o is stable until mem_aw_ready_i. Then go to DATA with beat=0.
- DATA: arr_word_o=beat and mem_wdata_o=arr_rdata_i (pass-through). mem_w_valid_o=1 and mem_wlast_o=(beat==7).
- Each w handshake increments beat (3-bit). The handshake with wlast goes to RESP; beat wraps to 0. With ready low, beat is held, so data stays stable.
- RESP: mem_b_ready_o=1. On b_valid: if mem_b_err_i, go to DONE with err_o=1 and leave dirty intact. Otherwise go to CLEAN.
- CLEAN: arr_we_o=1 for exactly one cycle, then DONE.
- DONE: done_o=1 with the qualifiers for one cycle, then IDLE.
- skipped_o and err_o are never both 1.
- The L2 controller must not write the latched index while busy_o=1. The engine does not detect this.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state=IDLE, req_ready_o=1.
- All other outputs reset to 0: valids, arr_we_o, done_o, busy_o, skipped_o, err_o, and the latched index/way/tag/beat.
- Reset mid-transaction abandons it. No dirty clear, no done_o pulse.
- Accept at cycle T → CHECK at T+1.
- Clean-line skip: done_o at T+2, req_ready_o at T+3.
- Dirty line with zero-wait memory (aw, w and b ready/valid on first cycle):
  - ADDR at T+2.
  - Beats at T+3..T+10.
  - RESP at T+11.
  - CLEAN at T+12.
  - done_o at T+13.
  - Next accept at T+14.
- A request presented while busy is not accepted. req_valid_i must be held by the requester.
- mem_addr_o, mem_wdata_o and mem_wlast_o must not change while their valid is high and ready is low.

## Structure
- Shared package cpu64_l2_pkg holds:
  - TAG_W, IDX_W, WAY_W, BEATS and LINE_BYTES=64.
  - The writeback state enum.
- Single module, no sub-module. The beat counter and FSM are inline.

## Test plan
- Clean line: valid=1, dirty=0 at index 0x12, way 3 → done_o at T+2 with skipped_o=1; no mem_aw_valid_o; arr_we_o never asserts.
- Dirty line, zero-wait: tag 0x2_0000_0000_0001, index 0x80, way 15, words 0x..00..0x..07 → mem_addr_o = {tag,8'h80,6'b0}; 8 beats in order with wlast on beat 7; arr_we_o one cycle with be=0, set_valid=1, set_dirty=0; done_o at T+13.
- Backpressure: mem_w_ready_i toggles 1,0,0,1,… and aw_ready is delayed 5 cycles → mem_addr_o and mem_wdata_o stay stable under stall; all 8 beats delivered exactly once, in order.
- Error response: mem_b_err_i=1 → done_o with err_o=1; arr_we_o never asserts; dirty bit still 1 afterwards.
- Reset mid-DATA: assert rst_i during beat 4 → next cycle req_ready_o=1 and all valids 0; no done_o pulse, no arr_we_o.
- Busy rejection: second req_valid_i during DATA → not accepted until the cycle after done_o; then processed normally.
